var_delay_line: RTL and testbench

Runtime-programmable, stallable synchronous delay line for NUM_BITS-wide data with a per-sample valid flag. It generalises the fixed delay register used throughout the cosim firmware. The delay is selectable from 1 to MAX_CYCLES at run time, the line can be frozen with a clock enable, and data that is stale after a delay change is tagged invalid. The block aligns data and control paths whose relative latency depends on the current operating mode, for example DSP filter taps or converter pipeline depth.

---
 rtl/var_delay_line_if.sv | 23 ++
 rtl/var_delay_line.sv | 52 +++++
 tb/tb_var_delay_line.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/var_delay_line_if.sv
// var_delay_line_if: data, control and status bundle of the variable delay line
interface var_delay_line_if #(
    parameter int NUM_BITS = 1,
    parameter int PTR_BITS = 4
);
    logic                en;
    logic [NUM_BITS-1:0] din;
    logic                din_valid;
    logic                delay_load;
    logic [PTR_BITS:0]   delay_in;
    logic [NUM_BITS-1:0] dout;
    logic                dout_valid;
    logic [PTR_BITS:0]   cur_delay;
    logic                primed;
    modport master (
        output en, din, din_valid, delay_load, delay_in,
        input  dout, dout_valid, cur_delay, primed
    );
    modport slave (
        input  en, din, din_valid, delay_load, delay_in,
        output dout, dout_valid, cur_delay, primed
    );
endinterface

// File: rtl/var_delay_line.sv
// var_delay_line: run-time programmable, stallable delay line built on a circular buffer
module var_delay_line #(
    parameter int NUM_BITS      = 1,
    parameter int MAX_CYCLES    = 16,
    parameter int PTR_BITS      = 4,
    parameter int DEFAULT_DELAY = 1
) (
    input logic             clk,
    input logic             reset,
    var_delay_line_if.slave io
);
    localparam logic [PTR_BITS:0]   MAXC = (PTR_BITS + 1)'(MAX_CYCLES);
    localparam logic [PTR_BITS:0]   DEF  = (PTR_BITS + 1)'(DEFAULT_DELAY);
    localparam logic [PTR_BITS-1:0] LAST = PTR_BITS'(MAX_CYCLES - 1);
    logic [NUM_BITS-1:0]   mem [MAX_CYCLES];
    logic [MAX_CYCLES-1:0] valid, valid_n;
    logic [PTR_BITS-1:0]   wptr, rptr;
    logic [PTR_BITS:0]     cur, fill, clamped, wext;
    assign wext    = {1'b0, wptr};
    // explicit wrap keeps the read tap correct for non power-of-two depths
    assign rptr    = PTR_BITS'(wext >= cur ? wext - cur : wext + MAXC - cur);
    assign clamped = io.delay_in == '0 ? (PTR_BITS + 1)'(1) :
                     io.delay_in > MAXC ? MAXC : io.delay_in;
    assign io.dout       = mem[rptr];
    assign io.dout_valid = valid[rptr];
    assign io.cur_delay  = cur;
    assign io.primed     = fill >= cur;
    always_comb begin
        valid_n = io.delay_load ? '0 : valid;
        if (io.en) valid_n[wptr] = io.din_valid;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            cur   <= DEF;
            fill  <= '0;
            valid <= '0;
            for (int i = 0; i < MAX_CYCLES; i++) mem[i] <= '0;
        end else begin
            valid <= valid_n;
            if (io.delay_load) begin
                cur  <= clamped;
                fill <= '0;
            end
            if (io.en) begin
                mem[wptr] <= io.din;
                wptr      <= wptr == LAST ? '0 : wptr + 1'b1;
                fill      <= io.delay_load ? (PTR_BITS + 1)'(1) : fill == MAXC ? fill : fill + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line: randomized check of two delay lines (depth 16 and 12) against a shift-chain model
module tb_var_delay_line;
    logic       clk = 0;
    logic       reset = 1;
    logic       en = 0;
    logic [7:0] din = '0;
    logic       din_valid = 0;
    logic       delay_load = 0;
    logic [4:0] delay_in = '0;
    int checks = 0;
    int errors = 0;
    logic [7:0] md [2][16];
    bit         mv [2][16];
    int         mcur [2];
    int         mfill [2];
    int         mmax [2] = '{16, 12};

    always #5 clk = ~clk;

    var_delay_line_if #(.NUM_BITS(8), .PTR_BITS(4)) ia ();
    var_delay_line_if #(.NUM_BITS(8), .PTR_BITS(4)) ib ();
    assign ia.en = en;
    assign ia.din = din;
    assign ia.din_valid = din_valid;
    assign ia.delay_load = delay_load;
    assign ia.delay_in = delay_in;
    assign ib.en = en;
    assign ib.din = din;
    assign ib.din_valid = din_valid;
    assign ib.delay_load = delay_load;
    assign ib.delay_in = delay_in;

    var_delay_line #(.NUM_BITS(8), .MAX_CYCLES(16), .PTR_BITS(4), .DEFAULT_DELAY(3))
        dut_a (.clk(clk), .reset(reset), .io(ia));
    var_delay_line #(.NUM_BITS(8), .MAX_CYCLES(12), .PTR_BITS(4), .DEFAULT_DELAY(3))
        dut_b (.clk(clk), .reset(reset), .io(ib));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    md[k][i] = '0;
                    mv[k][i] = 0;
                end
                mcur[k] = 3;
                mfill[k] = 0;
            end else begin
                if (delay_load) begin
                    mcur[k] = delay_in == 0 ? 1 : (int'(delay_in) > mmax[k] ? mmax[k] : int'(delay_in));
                    for (int i = 0; i < 16; i++) mv[k][i] = 0;
                    mfill[k] = 0;
                end
                if (en) begin
                    for (int i = mmax[k] - 1; i > 0; i--) begin
                        md[k][i] = md[k][i-1];
                        mv[k][i] = mv[k][i-1];
                    end
                    md[k][0] = din;
                    mv[k][0] = din_valid;
                    mfill[k] = mfill[k] + 1 > mmax[k] ? mmax[k] : mfill[k] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        check("a.dout", 32'(ia.dout), 32'(md[0][mcur[0]-1]));
        check("a.dout_valid", 32'(ia.dout_valid), 32'(mv[0][mcur[0]-1]));
        check("a.cur_delay", 32'(ia.cur_delay), mcur[0]);
        check("a.primed", 32'(ia.primed), 32'(mfill[0] >= mcur[0]));
        check("b.dout", 32'(ib.dout), 32'(md[1][mcur[1]-1]));
        check("b.dout_valid", 32'(ib.dout_valid), 32'(mv[1][mcur[1]-1]));
        check("b.cur_delay", 32'(ib.cur_delay), mcur[1]);
        check("b.primed", 32'(ib.primed), 32'(mfill[1] >= mcur[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic load(input int d, input logic e);
        delay_load = 1;
        delay_in = 5'(d);
        en = e;
        din = din + 8'd1;
        din_valid = 1;
        tick();
        delay_load = 0;
    endtask

    initial begin
        repeat (3) tick();
        check("reset.dout", 32'(ia.dout), 0);
        check("reset.cur_delay", 32'(ia.cur_delay), 3);
        reset = 0;
        for (int i = 1; i <= 10; i++) begin
            en = 1;
            din = 8'(i);
            din_valid = 1;
            tick();
        end
        load(4, 0);
        for (int i = 0; i < 20; i++) begin
            en = !(i >= 6 && i < 11);
            din = 8'(i + 20);
            tick();
        end
        load(2, 1);
        for (int i = 0; i < 6; i++) begin
            din = din + 8'd1;
            tick();
        end
        load(5, 1);
        for (int i = 0; i < 8; i++) begin
            din = din + 8'd1;
            tick();
        end
        load(0, 1);
        check("clamp0", 32'(ia.cur_delay), 1);
        tick();
        load(31, 1);
        check("clamp31.a", 32'(ia.cur_delay), 16);
        check("clamp31.b", 32'(ib.cur_delay), 12);
        for (int i = 0; i < 60; i++) begin
            en = 1;
            din = 8'($urandom);
            din_valid = 1'($urandom);
            tick();
        end
        for (int i = 0; i < 600; i++) begin
            en = $urandom_range(0, 3) != 0;
            din = 8'($urandom);
            din_valid = $urandom_range(0, 3) != 0;
            delay_load = $urandom_range(0, 19) == 0;
            delay_in = 5'($urandom);
            reset = $urandom_range(0, 99) == 0;
            tick();
        end
        reset = 0;
        delay_load = 0;
        en = 1;
        repeat (20) begin
            din = 8'($urandom);
            tick();
        end
        reset = 1;
        tick();
        check("midreset.dout_valid", 32'(ia.dout_valid), 0);
        check("midreset.primed", 32'(ib.primed), 0);
        reset = 0;
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
